weight_bias_fetch: RTL and testbench



---
 rtl/wb_fetch_pkg.sv | 20 ++
 rtl/wb_fetch_chan.sv | 69 ++++++
 rtl/weight_bias_fetch.sv | 114 +++++++++++
 tb/tb_weight_bias_fetch.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_fetch_pkg.sv
// Shared types and default parameters for the weight/bias fetch stage.
// The optional last-address cache is controlled by the WB_FETCH_CACHE_EN macro.
package wb_fetch_pkg;

    localparam int          WB_ADDR_W    = 16;
    localparam int          WB_DATA_W    = 16;
    localparam logic [15:0] WB_BIAS_BASE = 16'h8000;
    localparam int          WB_NUM_CH    = 2;

    typedef enum logic {
        WB_WEIGHT = 1'b0,
        WB_BIAS   = 1'b1
    } wb_chan_e;

    typedef struct packed {
        logic                 v;
        logic [WB_ADDR_W-1:0] addr;
    } wb_req_t;

endpackage

// File: rtl/wb_fetch_chan.sv
// One request channel: a one-deep pending slot (latest strobe wins) and,
// when WB_FETCH_CACHE_EN is defined, a single-entry last-address cache.
module wb_fetch_chan
    import wb_fetch_pkg::*;
#(
    parameter int ADDR_W = WB_ADDR_W,
    parameter int DATA_W = WB_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              strobe,
    input  logic [ADDR_W-1:0] addr,
    input  logic              issue,
    input  logic              in_flight,
    input  logic              cache_clr,
    input  logic              cap_en,
    input  logic [ADDR_W-1:0] cap_addr,
    input  logic [DATA_W-1:0] cap_data,
    output wb_req_t           pend,
    output logic              hit,
    output logic [DATA_W-1:0] hit_data
);

    logic load;

`ifdef WB_FETCH_CACHE_EN
    logic              c_v;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_data;

    // A hit is only honoured when the channel is idle so returns stay in order.
    assign hit      = strobe & c_v & (addr == c_addr) & ~pend.v & ~in_flight & ~cache_clr;
    assign hit_data = c_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_v    <= 1'b0;
            c_addr <= '0;
            c_data <= '0;
        end else if (cache_clr) begin
            c_v <= 1'b0;
        end else if (cap_en) begin
            c_v    <= 1'b1;
            c_addr <= cap_addr;
            c_data <= cap_data;
        end
    end
`else
    logic unused_cache;
    assign unused_cache = ^{in_flight, cache_clr, cap_en, cap_addr, cap_data};
    assign hit          = 1'b0;
    assign hit_data     = '0;
`endif

    assign load = strobe & ~hit;

    // A new strobe overrides a same-cycle issue: the issue already took the old address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend <= '0;
        end else if (load) begin
            pend.v    <= 1'b1;
            pend.addr <= addr;
        end else if (issue) begin
            pend.v <= 1'b0;
        end
    end

endmodule

// File: rtl/weight_bias_fetch.sv
// Serialises weight and bias read requests onto one single-port SRAM and
// returns registered data per channel. Optional cache: WB_FETCH_CACHE_EN.
module weight_bias_fetch
    import wb_fetch_pkg::*;
#(
    parameter int              ADDR_W    = WB_ADDR_W,
    parameter int              DATA_W    = WB_DATA_W,
    parameter logic [ADDR_W-1:0] BIAS_BASE = WB_BIAS_BASE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              read_weight_signal_data,
    input  logic [ADDR_W-1:0] read_weight_addr_data,
    input  logic              read_bias_signal_data,
    input  logic [ADDR_W-1:0] read_bias_addr_data,
    input  logic              cache_clr,
    output logic              mem_cs,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] weight_data,
    output logic              weight_valid,
    output logic [DATA_W-1:0] bias_data,
    output logic              bias_valid,
    output logic              busy
);

    logic [WB_NUM_CH-1:0]             strobe, grant, hit, cap_en;
    logic [WB_NUM_CH-1:0][ADDR_W-1:0] req_addr;
    logic [WB_NUM_CH-1:0][DATA_W-1:0] hit_data;
    wb_req_t                          pend [WB_NUM_CH];

    logic              tag_v;
    wb_chan_e          tag_ch;
    logic [ADDR_W-1:0] tag_addr;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [ADDR_W-1:0] issue_addr;
    logic [ADDR_W-1:0] issue_req_addr;

    assign strobe   = {read_bias_signal_data, read_weight_signal_data};
    assign req_addr = {read_bias_addr_data, read_weight_addr_data};

    assign cap_en[0] = tag_v & (tag_ch == WB_WEIGHT);
    assign cap_en[1] = tag_v & (tag_ch == WB_BIAS);

    for (genvar i = 0; i < WB_NUM_CH; i++) begin : g_ch
        wb_fetch_chan #(
            .ADDR_W (ADDR_W),
            .DATA_W (DATA_W)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .strobe    (strobe[i]),
            .addr      (req_addr[i]),
            .issue     (grant[i]),
            .in_flight (cap_en[i]),
            .cache_clr (cache_clr),
            .cap_en    (cap_en[i]),
            .cap_addr  (tag_addr),
            .cap_data  (mem_rdata),
            .pend      (pend[i]),
            .hit       (hit[i]),
            .hit_data  (hit_data[i])
        );
    end

    // Weight always wins the port; bias goes only when no weight is waiting.
    assign grant[0] = pend[0].v;
    assign grant[1] = ~pend[0].v & pend[1].v;
    assign mem_cs   = |grant;

    assign issue_req_addr = grant[0] ? pend[0].addr : pend[1].addr;
    assign issue_addr     = grant[0] ? pend[0].addr : pend[1].addr + BIAS_BASE;
    assign mem_addr       = mem_cs ? issue_addr : mem_addr_q;

    assign busy = pend[0].v | pend[1].v | tag_v;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_addr_q <= '0;
            tag_v      <= 1'b0;
            tag_ch     <= WB_WEIGHT;
            tag_addr   <= '0;
        end else begin
            mem_addr_q <= mem_addr;
            tag_v      <= mem_cs;
            if (mem_cs) begin
                tag_ch   <= grant[1] ? WB_BIAS : WB_WEIGHT;
                tag_addr <= issue_req_addr;
            end
        end
    end

    // A hit and a capture never coincide on one channel: hits require it idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            weight_data  <= '0;
            weight_valid <= 1'b0;
            bias_data    <= '0;
            bias_valid   <= 1'b0;
        end else begin
            weight_valid <= cap_en[0] | hit[0];
            bias_valid   <= cap_en[1] | hit[1];
            if (cap_en[0])
                weight_data <= mem_rdata;
            else if (hit[0])
                weight_data <= hit_data[0];
            if (cap_en[1])
                bias_data <= mem_rdata;
            else if (hit[1])
                bias_data <= hit_data[1];
        end
    end

endmodule

// File: tb/tb_weight_bias_fetch.sv
// Scoreboard bench for weight_bias_fetch: a request-level model predicts SRAM
// accesses and returned words; a negedge monitor checks what the DUT presents.
module tb_weight_bias_fetch;

    localparam logic [15:0] BASE = 16'h8000;
`ifdef WB_FETCH_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ws = 1'b0, bs = 1'b0, clr = 1'b0;
    logic [15:0] wa = '0, ba = '0;
    logic        mem_cs;
    logic [15:0] mem_addr;
    logic [15:0] mem_rdata = '0;
    logic [15:0] weight_data, bias_data;
    logic        weight_valid, bias_valid, busy;

    weight_bias_fetch dut (
        .clk                     (clk),
        .rst                     (rst),
        .read_weight_signal_data (ws),
        .read_weight_addr_data   (wa),
        .read_bias_signal_data   (bs),
        .read_bias_addr_data     (ba),
        .cache_clr               (clr),
        .mem_cs                  (mem_cs),
        .mem_addr                (mem_addr),
        .mem_rdata               (mem_rdata),
        .weight_data             (weight_data),
        .weight_valid            (weight_valid),
        .bias_data               (bias_data),
        .bias_valid              (bias_valid),
        .busy                    (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] sram_word(logic [15:0] a);
        if (a == 16'h0010) return 16'hABCD;
        return {a[6:0], a[15:7]} ^ 16'h5A3C;
    endfunction

    always @(posedge clk) if (mem_cs) mem_rdata <= sram_word(mem_addr);

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct { int cyc; logic [15:0] v; } ev_t;
    ev_t exp_mem[$], exp_w[$], exp_b[$];

    int checks = 0, failures = 0;
    task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, req);
        end
    endtask

    // Request-level model state
    logic        mp_v [2];
    logic [15:0] mp_a [2];
    logic        t_v;          // access issued last cycle (returns this cycle)
    int          t_ch;
    logic [15:0] t_addr, t_data;
    logic        cv [2];
    logic [15:0] ca [2], cd [2];
    logic        exp_busy = 1'b0;

    task automatic model_clear();
        exp_mem.delete(); exp_w.delete(); exp_b.delete();
        for (int i = 0; i < 2; i++) begin
            mp_v[i] = 1'b0; mp_a[i] = '0; cv[i] = 1'b0; ca[i] = '0; cd[i] = '0;
        end
        t_v = 1'b0; t_ch = 0; t_addr = '0; t_data = '0;
        exp_busy = 1'b0;
    endtask

    task automatic model_step();
        logic        s [2];
        logic [15:0] a [2];
        logic        iss, busy_ch;
        int          ich;
        logic [15:0] ireq, imem;
        s[0] = ws; s[1] = bs; a[0] = wa; a[1] = ba;
        exp_busy = mp_v[0] | mp_v[1] | t_v;
        iss = mp_v[0] | mp_v[1];
        ich = mp_v[0] ? 0 : 1;
        ireq = mp_a[ich];
        imem = (ich == 0) ? ireq : ireq + BASE;
        for (int i = 0; i < 2; i++) begin
            busy_ch = mp_v[i] | (t_v && t_ch == i);
            if (iss && ich == i) mp_v[i] = 1'b0;
            if (s[i]) begin
                if (CACHE && cv[i] && a[i] == ca[i] && !busy_ch && !clr) begin
                    if (i == 0) exp_w.push_back('{cyc + 1, cd[i]});
                    else        exp_b.push_back('{cyc + 1, cd[i]});
                end else begin
                    mp_v[i] = 1'b1; mp_a[i] = a[i];
                end
            end
        end
        if (iss) begin
            exp_mem.push_back('{cyc, imem});
            if (ich == 0) exp_w.push_back('{cyc + 2, sram_word(imem)});
            else          exp_b.push_back('{cyc + 2, sram_word(imem)});
        end
        if (clr) begin
            cv[0] = 1'b0; cv[1] = 1'b0;
        end else if (t_v) begin
            cv[t_ch] = 1'b1; ca[t_ch] = t_addr; cd[t_ch] = t_data;
        end
        t_v = iss; t_ch = ich; t_addr = ireq; t_data = sram_word(imem);
    endtask

    task automatic cycle(logic w_s, logic [15:0] w_a, logic b_s, logic [15:0] b_a, logic c);
        @(posedge clk); #1;
        ws = w_s; wa = w_a; bs = b_s; ba = b_a; clr = c;
        model_step();
    endtask

    task automatic idle(int n);
        repeat (n) cycle(1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; ws = 1'b0; bs = 1'b0; clr = 1'b0;
        model_clear();
        @(posedge clk); #1;
        chk("rst_mem_cs", mem_cs, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_weight_data", weight_data, 0);
        chk("rst_bias_data", bias_data, 0);
        chk("rst_valids", {weight_valid, bias_valid}, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        model_step();
    endtask

    // Monitor: pops expectations whenever the DUT presents an access or a return
    logic [15:0] last_ma = '0, last_wd = '0, last_bd = '0;
    ev_t e;
    always @(negedge clk) begin
        if (rst) begin
            last_ma = '0; last_wd = '0; last_bd = '0;
        end else begin
            chk("busy", busy, exp_busy);
            if (mem_cs) begin
                if (exp_mem.size() == 0) chk("mem_cs_unexpected", 1, 0);
                else begin
                    e = exp_mem.pop_front();
                    chk("mem_cs_cycle", cyc, e.cyc);
                    chk("mem_addr", mem_addr, e.v);
                    last_ma = e.v;
                end
            end else begin
                chk("mem_addr_hold", mem_addr, last_ma);
                if (exp_mem.size() != 0 && exp_mem[0].cyc <= cyc) begin
                    chk("mem_cs_missing", 0, 1);
                    void'(exp_mem.pop_front());
                end
            end
            if (weight_valid) begin
                if (exp_w.size() == 0) chk("weight_valid_unexpected", 1, 0);
                else begin
                    e = exp_w.pop_front();
                    chk("weight_valid_cycle", cyc, e.cyc);
                    chk("weight_data", weight_data, e.v);
                    last_wd = e.v;
                end
            end else begin
                chk("weight_data_hold", weight_data, last_wd);
                if (exp_w.size() != 0 && exp_w[0].cyc <= cyc) begin
                    chk("weight_valid_missing", 0, 1);
                    void'(exp_w.pop_front());
                end
            end
            if (bias_valid) begin
                if (exp_b.size() == 0) chk("bias_valid_unexpected", 1, 0);
                else begin
                    e = exp_b.pop_front();
                    chk("bias_valid_cycle", cyc, e.cyc);
                    chk("bias_data", bias_data, e.v);
                    last_bd = e.v;
                end
            end else begin
                chk("bias_data_hold", bias_data, last_bd);
                if (exp_b.size() != 0 && exp_b[0].cyc <= cyc) begin
                    chk("bias_valid_missing", 0, 1);
                    void'(exp_b.pop_front());
                end
            end
        end
    end

    initial begin
        model_clear();
        do_reset();
        // single weight miss, SRAM word 0xABCD
        cycle(1'b1, 16'h0010, 1'b0, '0, 1'b0);
        idle(5);
        // simultaneous weight and bias
        cycle(1'b1, 16'h0004, 1'b1, 16'h0002, 1'b0);
        idle(5);
        // bias address wraps past the top of the SRAM
        cycle(1'b0, '0, 1'b1, 16'h9000, 1'b0);
        idle(5);
        // back-to-back weights
        for (int i = 0; i < 4; i++) cycle(1'b1, 16'(i), 1'b0, '0, 1'b0);
        idle(5);
        // bias overwritten while weight traffic holds the port
        cycle(1'b1, 16'h0100, 1'b1, 16'h0011, 1'b0);
        cycle(1'b1, 16'h0101, 1'b1, 16'h0022, 1'b0);
        idle(6);
        // reset right after a strobe
        cycle(1'b1, 16'h0033, 1'b1, 16'h0044, 1'b0);
        do_reset();
        idle(6);
        // repeat address (hit when cached), then clear and repeat (miss)
        cycle(1'b1, 16'h0020, 1'b0, '0, 1'b0);
        idle(5);
        cycle(1'b1, 16'h0020, 1'b0, '0, 1'b0);
        idle(3);
        cycle(1'b0, '0, 1'b0, '0, 1'b1);
        cycle(1'b1, 16'h0020, 1'b0, '0, 1'b0);
        idle(5);
        // clear coinciding with a would-be hit
        cycle(1'b1, 16'h0020, 1'b0, '0, 1'b1);
        idle(5);
        // randomized traffic
        for (int n = 0; n < 1500; n++) begin
            logic [15:0] rw, rb;
            rw = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(16'h20, 16'h23));
            rb = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(16'h7FFE, 16'h8001));
            if ($urandom_range(0, 299) == 0) do_reset();
            else cycle($urandom_range(0, 2) == 0, rw, $urandom_range(0, 2) == 0, rb,
                       $urandom_range(0, 19) == 0);
        end
        idle(8);
        chk("drain_mem", exp_mem.size(), 0);
        chk("drain_weight", exp_w.size(), 0);
        chk("drain_bias", exp_b.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
